// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and address-field width helpers
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

  // beat counter keeps at least one bit so single-word lines still have a counter
  function automatic int cnt_w(input int line_words);
    return line_words > 1 ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/cache_hit_compare.sv
// cache_hit_compare: two-way valid/tag compare with word select for the addressed set
module cache_hit_compare
  import cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int ADDR_W     = 19
) (
  input  logic [1:0]                            valid,
  input  logic [tag_w(ADDR_W,SETS,LINE_WORDS)-1:0] tag0,
  input  logic [tag_w(ADDR_W,SETS,LINE_WORDS)-1:0] tag1,
  input  logic [31:0]                           address,
  output logic                                  hit,
  output logic                                  hit_way,
  output logic [cnt_w(LINE_WORDS)-1:0]          word_sel
);

  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int CW = cnt_w(LINE_WORDS);

  logic [TW-1:0] tag;
  logic          m0, m1;

  // way 0 wins if both ways claim the address
  always_comb begin
    tag      = TW'(address >> (2 + OW + IW));
    m0       = valid[0] && tag0 == tag;
    m1       = valid[1] && tag1 == tag;
    hit      = m0 || m1;
    hit_way  = !m0 && m1;
    word_sel = CW'((address >> 2) & 32'(LINE_WORDS - 1));
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// set_assoc_cache_ctrl: 2-way write-through, no-write-allocate data cache with multi-beat refill
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int ADDR_W     = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int CW = cnt_w(LINE_WORDS);

  state_t        state;
  logic [31:0]   mem   [SETS][2][LINE_WORDS];
  logic [TW-1:0] tags  [SETS][2];
  logic [1:0]    valid [SETS];
  logic [SETS-1:0] lru;
  logic [31:0]   fbuf  [LINE_WORDS];
  logic [CW-1:0] beat;
  logic          victim;
  logic [31:0]   base;
  logic [IW-1:0] idx, fidx;
  logic [TW-1:0] ftag;
  logic          hit, hit_way, last_beat, we_hit, we_fill;
  logic [CW-1:0] wsel;

  cache_hit_compare #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) u_cmp (
    .valid   (valid[idx]),
    .tag0    (tags[idx][0]),
    .tag1    (tags[idx][1]),
    .address (address),
    .hit     (hit),
    .hit_way (hit_way),
    .word_sel(wsel)
  );

  // address fields, array write strobes and pipeline/SRAM-side outputs (forced quiet in reset)
  always_comb begin
    idx        = IW'(address >> (2 + OW));
    fidx       = IW'(base >> (2 + OW));
    ftag       = TW'(base >> (2 + OW + IW));
    last_beat  = beat == CW'(LINE_WORDS - 1);
    we_hit     = rst && state == IDLE && wr_en && hit;
    we_fill    = rst && state == FILL && sram_ready && last_beat;
    ready      = !rst ? 1'b1 :
                 state == IDLE  ? !wr_en && (!rd_en || hit) :
                 state == WRITE ? sram_ready : 1'b0;
    sram_wr_en = rst && state == WRITE;
    sram_rd_en = rst && state == FILL;
    sram_addr  = sram_wr_en ? address & ~32'd3 :
                 sram_rd_en ? base + (32'(beat) << 2) : 32'd0;
    sram_wdata = sram_wr_en ? wdata : 32'd0;
    rdata      = rst && hit ? mem[idx][hit_way][wsel] : 32'd0;
  end

  // data and tag arrays: write-hit word update and whole-line refill, never reset
  always_ff @(posedge clk) begin
    if (we_hit) mem[idx][hit_way][wsel] <= wdata;
    if (we_fill) begin
      for (int w = 0; w < LINE_WORDS; w++)
        mem[fidx][victim][w] <= w == LINE_WORDS - 1 ? sram_rdata : fbuf[w];
      tags[fidx][victim] <= ftag;
    end
  end

  // controller FSM with valid/LRU bookkeeping and fill sequencing
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= '0;
      lru   <= '0;
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            state <= WRITE;
            if (hit) lru[idx] <= !hit_way;
          end else if (rd_en && hit) begin
            lru[idx] <= !hit_way;
          end else if (rd_en) begin
            base   <= address & ~32'(LINE_WORDS * 4 - 1);
            victim <= !valid[idx][0] ? 1'b0 : !valid[idx][1] ? 1'b1 : lru[idx];
            beat   <= '0;
            state  <= FILL;
          end
        end
        WRITE: if (sram_ready) state <= IDLE;
        FILL: begin
          if (sram_ready) begin
            fbuf[beat] <= sram_rdata;
            beat       <= last_beat ? '0 : beat + CW'(1);
            if (last_beat) begin
              valid[fidx][victim] <= 1'b1;
              lru[fidx]           <= !victim;
              state               <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// tb_set_assoc_cache_ctrl: random read/write traffic checked against a set/way/LRU reference model
module tb_set_assoc_cache_ctrl;

  localparam int SETS = 64;
  localparam int LW   = 2;
  localparam int AW   = 19;

  logic        clk = 0, rst = 0, rd_en = 0, wr_en = 0, sram_ready = 0;
  logic [31:0] address = 0, wdata = 0, sram_rdata = 0;
  logic [31:0] rdata, sram_addr, sram_wdata;
  logic        ready, sram_rd_en, sram_wr_en;

  int n_cmp = 0, n_bad = 0;

  bit          m_valid [SETS][2];
  int unsigned m_tag   [SETS][2];
  logic [31:0] m_data  [SETS][2][LW];
  bit          m_lru   [SETS];

  set_assoc_cache_ctrl #(.SETS(SETS), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sdata(input logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
  endfunction

  function automatic int field_set(input logic [31:0] a);
    return int'(((a % (1 << AW)) / 4 / LW) % SETS);
  endfunction

  function automatic int unsigned field_tag(input logic [31:0] a);
    return (a % (1 << AW)) / 4 / (LW * SETS);
  endfunction

  function automatic int field_off(input logic [31:0] a);
    return int'(((a % (1 << AW)) / 4) % LW);
  endfunction

  function automatic int find_way(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (m_valid[field_set(a)][w] && m_tag[field_set(a)][w] == field_tag(a)) return w;
    return -1;
  endfunction

  function automatic logic [31:0] make_addr(input int unsigned t, input int s);
    return t * (LW * SETS * 4) + s * (LW * 4) + $urandom_range(0, LW - 1) * 4
           + $urandom_range(0, 3) + ($urandom_range(0, 1) << 24);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle();
    rd_en = 0; wr_en = 0;
    sram_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_ready", ready, 1);
    check("idle_srd", sram_rd_en, 0);
    check("idle_swr", sram_wr_en, 0);
    check("idle_saddr", sram_addr, 0);
    step();
    sram_ready = 0;
  endtask

  task automatic do_read(input logic [31:0] a);
    int s, o, w, v, lat, sum, stall;
    logic [31:0] base;
    s = field_set(a); o = field_off(a); w = find_way(a);
    rd_en = 1; wr_en = 0; address = a;
    if (w >= 0) begin
      @(negedge clk);
      check("rd_hit_ready", ready, 1);
      check("rd_hit_data", rdata, m_data[s][w][o]);
      check("rd_hit_srd", sram_rd_en, 0);
      step();
      m_lru[s] = !w[0];
    end else begin
      v = !m_valid[s][0] ? 0 : !m_valid[s][1] ? 1 : int'(m_lru[s]);
      base = a & ~32'(LW * 4 - 1);
      sum = 0; stall = 0;
      @(negedge clk);
      check("miss_detect_ready", ready, 0);
      check("miss_rdata", rdata, 0);
      check("miss_detect_srd", sram_rd_en, 0);
      if (!ready) stall++;
      step();
      for (int b = 0; b < LW; b++) begin
        lat = $urandom_range(1, 4);
        sum += lat;
        for (int c = 0; c < lat; c++) begin
          if (c == lat - 1) begin
            sram_ready = 1;
            sram_rdata = sdata(base + 32'(4 * b));
          end
          @(negedge clk);
          check("fill_srd", sram_rd_en, 1);
          check("fill_swr", sram_wr_en, 0);
          check("fill_addr", sram_addr, base + 32'(4 * b));
          if (!ready) stall++;
          step();
          sram_ready = 0;
          sram_rdata = $urandom;
        end
      end
      m_valid[s][v] = 1;
      m_tag[s][v] = field_tag(a);
      for (int b = 0; b < LW; b++) m_data[s][v][b] = sdata(base + 32'(4 * b));
      @(negedge clk);
      check("retry_ready", ready, 1);
      check("retry_data", rdata, m_data[s][v][o]);
      check("miss_stall_cycles", stall, 1 + sum);
      step();
      m_lru[s] = !v[0];
    end
    rd_en = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
    int s, o, w, lat;
    s = field_set(a); o = field_off(a); w = find_way(a);
    rd_en = both; wr_en = 1; address = a; wdata = d;
    @(negedge clk);
    check("wr_detect_ready", ready, 0);
    check("wr_detect_swr", sram_wr_en, 0);
    step();
    if (w >= 0) begin
      m_data[s][w][o] = d;
      m_lru[s] = !w[0];
    end
    lat = $urandom_range(1, 4);
    for (int c = 0; c < lat; c++) begin
      if (c == lat - 1) sram_ready = 1;
      @(negedge clk);
      check("wr_swr", sram_wr_en, 1);
      check("wr_srd", sram_rd_en, 0);
      check("wr_addr", sram_addr, a & ~32'd3);
      check("wr_wdata", sram_wdata, d);
      check("wr_ready", ready, 32'(c == lat - 1));
      step();
      sram_ready = 0;
    end
    rd_en = 0; wr_en = 0;
  endtask

  initial begin
    logic [31:0] a, a0, b0;
    int op;
    rst = 0; rd_en = 1; address = 32'h40;
    step(); step();
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_srd", sram_rd_en, 0);
    check("rst_swr", sram_wr_en, 0);
    check("rst_saddr", sram_addr, 0);
    check("rst_swdata", sram_wdata, 0);
    check("rst_rdata", rdata, 0);
    step();
    rst = 1; rd_en = 0;
    do_idle();

    // read hit in set 5 after a fill
    a0 = make_addr(32'h12A, 5);
    do_read(a0);
    do_read(a0);
    // LRU eviction in set 3
    do_read(make_addr(1, 3));
    do_read(make_addr(2, 3));
    do_read(make_addr(1, 3));
    do_read(make_addr(3, 3));
    do_read(make_addr(1, 3));
    do_read(make_addr(2, 3));
    // write hit, then write miss followed by a read of the uncached line
    do_write(a0, 32'hDEAD_BEEF, 0);
    do_read(a0);
    do_write(make_addr(7, 9), 32'h1234_5678, 0);
    do_read(make_addr(7, 9));

    for (int i = 0; i < 400; i++) begin
      a = make_addr($urandom_range(0, 3), $urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op < 6) do_read(a);
      else if (op < 8) do_write(a, $urandom, 0);
      else if (op == 8) do_write(a, $urandom, 1);
      else do_idle();
    end

    // reset during a fill, after beat 0
    do_read(a0);
    b0 = make_addr(32'h3FF, 7);
    while (find_way(b0) >= 0) b0 = make_addr(32'h3FE, 7);
    rd_en = 1; address = b0;
    step();
    sram_ready = 1; sram_rdata = 32'hCAFE_F00D;
    step();
    sram_ready = 0;
    rst = 0;
    @(negedge clk);
    check("midfill_rst_ready", ready, 1);
    check("midfill_rst_srd", sram_rd_en, 0);
    check("midfill_rst_saddr", sram_addr, 0);
    check("midfill_rst_rdata", rdata, 0);
    step();
    rst = 1; rd_en = 0;
    for (int s = 0; s < SETS; s++) begin
      m_valid[s][0] = 0; m_valid[s][1] = 0; m_lru[s] = 0;
    end
    @(negedge clk);
    check("post_rst_srd", sram_rd_en, 0);
    check("post_rst_ready", ready, 1);
    step();
    do_read(a0);
    do_read(b0);
    do_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
